// File: rtl/fc_layer_param_if.sv
// rtl/fc_layer_param_if.sv - control, ROM/RAM and MultAdder bus of the fully-connected layer engine
//
// Purpose: bundles every fc_layer_param signal except clk/iRst.
// slave modport : the layer engine (fc_layer_param)
// master modport: whatever drives the engine (controller, ROM/RAM, MultAdder)
// Signals:
//   ena, start, relu_en        control into the engine
//   busy, done, overflow       run status out of the engine
//   addr_to_rom/data_from_rom  weight/bias ROM read port
//   data_from_ram              input activation vector
//   opr1/opr2_to_MultAdder     dot-product operands
//   data_from_MultAdder, overflow_from_MultAdder  dot-product result
//   data_to_ram                result vector, one byte per neuron
interface fc_layer_param_if #(
    parameter int N_OUT     = 10,
    parameter int VEC_BYTES = 128,
    parameter int ROM_AW    = 11
);
    logic                     ena;
    logic                     start;
    logic                     relu_en;
    logic [VEC_BYTES*8-1:0]   data_from_rom;
    logic [VEC_BYTES*8-1:0]   data_from_ram;
    logic [14:0]              data_from_MultAdder;
    logic                     overflow_from_MultAdder;
    logic                     busy;
    logic                     done;
    logic                     overflow;
    logic [ROM_AW-1:0]        addr_to_rom;
    logic [VEC_BYTES*8-1:0]   opr1_to_MultAdder;
    logic [VEC_BYTES*8-1:0]   opr2_to_MultAdder;
    logic [N_OUT*8-1:0]       data_to_ram;

    modport slave (
        input  ena, start, relu_en, data_from_rom, data_from_ram,
               data_from_MultAdder, overflow_from_MultAdder,
        output busy, done, overflow, addr_to_rom, opr1_to_MultAdder,
               opr2_to_MultAdder, data_to_ram
    );

    modport master (
        output ena, start, relu_en, data_from_rom, data_from_ram,
               data_from_MultAdder, overflow_from_MultAdder,
        input  busy, done, overflow, addr_to_rom, opr1_to_MultAdder,
               opr2_to_MultAdder, data_to_ram
    );
endinterface

// File: rtl/fc_layer_param.sv
// rtl/fc_layer_param.sv - fully-connected layer sequencer with bias add and optional ReLU
//
// float8_adder: combinational adder for the 15-bit extended Float8 format
//   {sign, exp[3:0], mant[9:0]}, hidden bit when exp!=0, exp 0 is subnormal.
//   a_i, b_i in; sum_o out (saturated on overflow); ovf_o out.
// fc_layer_param: per neuron fetches the weight row, waits MAC_LAT cycles for
//   the external MultAdder, adds the bias and writes one result byte.
//   clk, iRst (async, active-high) plain ports; everything else on bus (slave).

module float8_adder (
    input  logic [14:0] a_i,
    input  logic [14:0] b_i,
    output logic [14:0] sum_o,
    output logic        ovf_o
);
    logic        a_big;
    logic [14:0] big, sml;
    logic [4:0]  eb, es, e_n;
    logic [10:0] mb, ms, ms_sh, m_n;
    logic [11:0] msum;

    always_comb begin
        // Magnitude compare on the packed exp/mantissa bits orders the operands,
        // so the subtract path never goes negative.
        a_big = (a_i[13:0] >= b_i[13:0]);
        big   = a_big ? a_i : b_i;
        sml   = a_big ? b_i : a_i;
        eb    = (big[13:10] == 4'd0) ? 5'd1 : {1'b0, big[13:10]};
        es    = (sml[13:10] == 4'd0) ? 5'd1 : {1'b0, sml[13:10]};
        mb    = {big[13:10] != 4'd0, big[9:0]};
        ms    = {sml[13:10] != 4'd0, sml[9:0]};
        ms_sh = ms >> (eb - es);
        if (big[14] == sml[14]) begin
            msum = {1'b0, mb} + {1'b0, ms_sh};
        end else begin
            msum = {1'b0, mb} - {1'b0, ms_sh};
        end
        e_n = eb;
        m_n = msum[10:0];
        if (msum[11]) begin
            m_n = msum[11:1];
            e_n = eb + 5'd1;
        end else begin
            // Left-normalise, but never below exponent 1 (subnormal floor).
            for (int i = 0; i < 10; i++) begin
                if (!m_n[10] && (e_n > 5'd1)) begin
                    m_n = m_n << 1;
                    e_n = e_n - 5'd1;
                end
            end
        end
        if (!m_n[10]) begin
            e_n = 5'd0;
        end
        ovf_o = (e_n > 5'd15);
        if (ovf_o) begin
            sum_o = {big[14], 14'h3FFF};
        end else begin
            sum_o = {(m_n == 11'd0) ? 1'b0 : big[14], e_n[3:0], m_n[9:0]};
        end
    end
endmodule

module fc_layer_param #(
    parameter int                N_OUT     = 10,
    parameter int                VEC_BYTES = 128,
    parameter int                ROM_AW    = 11,
    parameter logic [ROM_AW-1:0] W_BASE    = 11'h401,
    parameter logic [ROM_AW-1:0] B_BASE    = 11'h40b,
    parameter int                MAC_LAT   = 1
) (
    input  logic             clk,
    input  logic             iRst,
    fc_layer_param_if.slave  bus
);
    localparam int RW = $clog2(N_OUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_BREQ, S_BGET, S_WREQ, S_LOAD, S_WAIT, S_ADD, S_STORE, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic                   relu_q, relu_d, add_ovf_q, add_ovf_d;
    logic [ROM_AW-1:0]      addr_q, addr_d;
    logic [VEC_BYTES*8-1:0] opr1_q, opr1_d, opr2_q, opr2_d;
    logic [N_OUT*8-1:0]     res_q, res_d, bias_q, bias_d;
    logic [14:0]            sum_q, sum_d, add_a, add_sum;
    logic                   add_ovf, last_row, accept;
    logic [7:0]             res_byte;

    assign add_a    = {bias_q[8*int'(row_q) +: 8], 7'b0};
    assign last_row = (int'(row_q) + 1 >= N_OUT);
    assign accept   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // Negative zero passes through; any other negative value clamps under ReLU.
    assign res_byte = (!relu_q || !sum_q[14] || (sum_q[13:7] == 7'd0)) ? sum_q[14:7] : 8'h00;

    float8_adder u_add (
        .a_i   (add_a),
        .b_i   (bus.data_from_MultAdder),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            relu_q    <= 1'b0;
            add_ovf_q <= 1'b0;
            addr_q    <= '0;
            opr1_q    <= '0;
            opr2_q    <= '0;
            res_q     <= '0;
            bias_q    <= '0;
            sum_q     <= '0;
        end else if (bus.ena) begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            relu_q    <= relu_d;
            add_ovf_q <= add_ovf_d;
            addr_q    <= addr_d;
            opr1_q    <= opr1_d;
            opr2_q    <= opr2_d;
            res_q     <= res_d;
            bias_q    <= bias_d;
            sum_q     <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (accept) state_d = S_BREQ;
            S_BREQ:  state_d = S_BGET;
            S_BGET:  state_d = S_WREQ;
            S_WREQ:  state_d = S_LOAD;
            S_LOAD:  state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_ADD;
            S_ADD:   state_d = S_STORE;
            S_STORE: state_d = last_row ? S_DONE : S_WREQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row_d     = row_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        relu_d    = relu_q;
        add_ovf_d = add_ovf_q;
        addr_d    = addr_q;
        opr1_d    = opr1_q;
        opr2_d    = opr2_q;
        res_d     = res_q;
        bias_d    = bias_q;
        sum_d     = sum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    row_d  = '0;
                    ovf_d  = 1'b0;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                    relu_d = bus.relu_en;
                    addr_d = B_BASE;
                end
            end
            S_BGET: begin
                bias_d = bus.data_from_rom[N_OUT*8-1:0];
                addr_d = W_BASE + ROM_AW'(row_q);
            end
            S_LOAD: begin
                opr1_d = bus.data_from_ram;
                opr2_d = bus.data_from_rom;
                cnt_d  = 4'(MAC_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            S_ADD: begin
                sum_d     = add_sum;
                add_ovf_d = add_ovf;
                ovf_d     = ovf_q | bus.overflow_from_MultAdder;
            end
            S_STORE: begin
                ovf_d = ovf_q | add_ovf_q;
                res_d[8*int'(row_q) +: 8] = res_byte;
                row_d = row_q + RW'(1);
                if (last_row) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    addr_d = W_BASE + ROM_AW'(row_q) + ROM_AW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.overflow          = ovf_q;
    assign bus.addr_to_rom       = addr_q;
    assign bus.opr1_to_MultAdder = opr1_q;
    assign bus.opr2_to_MultAdder = opr2_q;
    assign bus.data_to_ram       = res_q;
endmodule

// File: tb/tb_fc_layer_param.sv
// tb/tb_fc_layer_param.sv - directed self-checking bench for fc_layer_param (default and N_OUT=4/MAC_LAT=3)
module tb_fc_layer_param;
    logic clk = 1'b0;
    logic iRst;
    always #5 clk = ~clk;

    fc_layer_param_if bus_a ();
    fc_layer_param_if #(.N_OUT(4)) bus_b ();

    fc_layer_param dut_a (.clk(clk), .iRst(iRst), .bus(bus_a.slave));
    fc_layer_param #(.N_OUT(4), .MAC_LAT(3)) dut_b (.clk(clk), .iRst(iRst), .bus(bus_b.slave));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [14:0] mac_tab [16];
    logic [1023:0] bias_vec;
    logic [7:0]  ovf_row;
    logic [79:0] peek;
    logic [10:0] alog [$];

    function automatic logic [1023:0] rom_fn(input logic [10:0] a);
        logic [1023:0] d;
        d = '0;
        if (a == 11'h40b) d = bias_vec;
        else if (a >= 11'h401 && a < 11'h40b) d[7:0] = 8'(a - 11'h401);
        return d;
    endfunction

    // ROM answers one cycle after the address; MultAdder keys off the row tag in the weight.
    always @(posedge clk) begin
        bus_a.data_from_rom <= rom_fn(bus_a.addr_to_rom);
        bus_b.data_from_rom <= rom_fn(bus_b.addr_to_rom);
    end
    always_comb begin
        bus_a.data_from_MultAdder     = mac_tab[bus_a.opr2_to_MultAdder[3:0]];
        bus_a.overflow_from_MultAdder = (bus_a.opr2_to_MultAdder[7:0] == ovf_row);
        bus_b.data_from_MultAdder     = mac_tab[bus_b.opr2_to_MultAdder[3:0]];
        bus_b.overflow_from_MultAdder = 1'b0;
    end
    assign bus_a.data_from_ram = {128{8'h3C}};
    assign bus_b.data_from_ram = {128{8'h3C}};

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_a(input bit relu, input int freeze_at, input int start_at,
                         input int rst_at, input int peek_at, output int lat);
        @(negedge clk);
        bus_a.relu_en = relu;
        bus_a.start   = 1'b1;
        @(posedge clk); #1;
        bus_a.start   = 1'b0;
        bus_a.relu_en = ~relu;
        lat = 0;
        while (!bus_a.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == peek_at) peek = bus_a.data_to_ram;
            if (lat == freeze_at) bus_a.ena = 1'b0;
            if (lat == freeze_at + 6) bus_a.ena = 1'b1;
            if (lat == start_at) bus_a.start = 1'b1;
            if (lat == start_at + 1) bus_a.start = 1'b0;
            if (lat == rst_at) begin
                iRst = 1'b1;
                #1;
                break;
            end
        end
    endtask

    localparam int OFF = 1000;
    int lat;
    logic [10:0] exp_addr [5];

    initial begin
        for (int i = 0; i < 16; i++) mac_tab[i] = 15'h0A00;
        bias_vec = '0;
        ovf_row  = 8'hFF;
        peek     = '0;
        bus_a.ena = 1'b1; bus_a.start = 1'b0; bus_a.relu_en = 1'b0;
        bus_b.ena = 1'b1; bus_b.start = 1'b0; bus_b.relu_en = 1'b0;
        iRst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        iRst = 1'b0;
        #1;
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.done, 0);
        check("rst_ovf", bus_a.overflow, 0);
        check("rst_addr", bus_a.addr_to_rom, 0);
        check("rst_opr1", bus_a.opr1_to_MultAdder, 0);
        check("rst_data", bus_a.data_to_ram, 0);

        // Basic run
        run_a(0, OFF, OFF, OFF, OFF, lat);
        check("basic_lat", lat, 52);
        check("basic_data", bus_a.data_to_ram, {10{8'h14}});
        check("basic_ovf", bus_a.overflow, 0);
        check("basic_busy", bus_a.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", bus_a.done, 1);

        // Negative row 3 with and without ReLU
        mac_tab[3] = 15'h4A00;
        run_a(1, OFF, OFF, OFF, OFF, lat);
        check("relu_data", bus_a.data_to_ram, {{6{8'h14}}, 8'h00, {3{8'h14}}});
        run_a(0, OFF, OFF, OFF, OFF, lat);
        check("lin_data", bus_a.data_to_ram, {{6{8'h14}}, 8'h94, {3{8'h14}}});

        // Bias on row 0: 0x0A00 + 0x0A00 = 0x0E00 -> 0x1C; row 3 keeps 0x94 until rewritten
        mac_tab[3] = 15'h0A00;
        bias_vec[7:0] = 8'h14;
        run_a(0, OFF, OFF, OFF, 7, lat);
        check("bias_peek", peek, {{6{8'h14}}, 8'h94, 8'h14, 8'h14, 8'h1C});
        check("bias_data", bus_a.data_to_ram, {{9{8'h14}}, 8'h1C});
        bias_vec = '0;

        // Overflow on row 7 only
        ovf_row = 8'd7;
        run_a(0, OFF, OFF, OFF, OFF, lat);
        check("ovf_set", bus_a.overflow, 1);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_sticky", bus_a.overflow, 1);
        ovf_row = 8'hFF;
        run_a(0, OFF, OFF, OFF, OFF, lat);
        check("ovf_clear", bus_a.overflow, 0);
        check("ovf_clear_lat", lat, 52);

        // Reset during row 5 WAIT
        run_a(0, OFF, OFF, 29, OFF, lat);
        check("abort_busy", bus_a.busy, 0);
        check("abort_done", bus_a.done, 0);
        check("abort_addr", bus_a.addr_to_rom, 0);
        check("abort_opr2", bus_a.opr2_to_MultAdder, 0);
        check("abort_data", bus_a.data_to_ram, 0);
        @(negedge clk);
        iRst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_idle_busy", bus_a.busy, 0);
        check("abort_idle_done", bus_a.done, 0);
        run_a(0, OFF, OFF, OFF, OFF, lat);
        check("after_rst_lat", lat, 52);
        check("after_rst_data", bus_a.data_to_ram, {10{8'h14}});

        // Freeze 6 cycles in row 2 plus an ignored start
        run_a(0, 13, 30, OFF, OFF, lat);
        check("freeze_lat", lat, 58);
        check("freeze_data", bus_a.data_to_ram, {10{8'h14}});
        check("freeze_ovf", bus_a.overflow, 0);

        // Small configuration
        exp_addr = '{11'h40b, 11'h401, 11'h402, 11'h403, 11'h404};
        @(negedge clk);
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        alog.push_back(bus_b.addr_to_rom);
        lat = 0;
        while (!bus_b.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bus_b.addr_to_rom != alog[$]) alog.push_back(bus_b.addr_to_rom);
        end
        check("small_lat", lat, 30);
        check("small_data", bus_b.data_to_ram, 32'h14141414);
        check("small_addr_n", alog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < alog.size()) check($sformatf("small_addr%0d", i), alog[i], exp_addr[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fc_layer_param.md
FC_LAYER_PARAM -- requirements
Module: fc_layer_param

Interface
REQ-001 Parameter N_OUT, 10, number of output neurons (rows); legal 1..VEC_BYTES.
REQ-002 Parameter VEC_BYTES, 128, operand vector length in 8-bit Float8 elements.
REQ-003 Parameter ROM_AW, 11, ROM address width.
REQ-004 Parameter W_BASE, 11'h401, ROM address of weight row 0; row r is at W_BASE+r.
REQ-005 Parameter B_BASE, 11'h40b, ROM address of the packed bias vector; bias r is at byte r.
REQ-006 Parameter MAC_LAT, 1, cycles from operand presentation to valid MultAdder result; legal 1..15.
REQ-007 clk  in  1  single clock; all state changes on the rising edge.
REQ-008 iRst  in  1  reset; asynchronous and active-high.
REQ-009 ena  in  1  block enable; low freezes the FSM and all registers.
REQ-010 start  in  1  one-cycle request to run the layer.
REQ-011 relu_en  in  1  1 = apply ReLU on outputs; 0 = linear output; sampled at start.
REQ-012 data_from_rom  in  VEC_BYTES*8  ROM read data, valid one cycle after addr_to_rom changes.
REQ-013 data_from_ram  in  VEC_BYTES*8  input activation vector; stable for the whole run.
REQ-014 data_from_MultAdder  in  15  Float8 dot-product result, extended format.
REQ-015 overflow_from_MultAdder  in  1  dot-product overflow flag.
REQ-016 busy  out  1  high from the start-accept edge until the edge that enters DONE.
REQ-017 done  out  1  high in DONE, held until the next accepted start or reset.
REQ-018 overflow  out  1  sticky OR of every overflow in the current run.
REQ-019 addr_to_rom  out  ROM_AW  ROM read address.
REQ-020 opr1_to_MultAdder / opr2_to_MultAdder  out  VEC_BYTES*8 each  activation / weight operands.
REQ-021 data_to_ram  out  N_OUT*8  result vector; neuron r occupies bits [8r+7:8r].

Function
REQ-022 States: IDLE, BREQ, BGET, WREQ, LOAD, WAIT, ADD, STORE, DONE; each lasts one cycle except WAIT, which lasts MAC_LAT cycles, counted by an internal down-counter.
REQ-023 IDLE or DONE with start=1 -> BREQ; clear row counter, overflow, and done; latch relu_en; set busy.
REQ-024 BREQ: drive addr_to_rom=B_BASE -> BGET; BGET: latch data_from_rom into the bias register -> WREQ.
REQ-025 WREQ: drive addr_to_rom=W_BASE+row -> LOAD; LOAD: opr1<=data_from_ram, opr2<=data_from_rom -> WAIT.
REQ-026 Last WAIT cycle -> ADD: adder inputs are {bias[row],7'b0} and data_from_MultAdder; overflow |= overflow_from_MultAdder.
REQ-027 Addition uses an internal Float8Adder on 15-bit operands; no extra pipeline stage.
REQ-028 STORE: overflow |= adder overflow; write byte row of data_to_ram; increment row; go to WREQ if row+1<N_OUT, else go to DONE, set done, and clear busy.
REQ-029 Output byte = adder_sum[14:7] when relu_en=0, or when adder_sum[14]=0, or when adder_sum[13:7]=0; otherwise 8'h00.
REQ-030 Run latency: done rises on the 2+N_OUT*(4+MAC_LAT)-th rising edge after the start-accept edge (52 with default parameters).
REQ-031 start while busy is ignored and does not affect the run in progress.
REQ-032 ena=0: all state and outputs hold; the run resumes on the first edge with ena=1, and latency excludes frozen cycles.
REQ-033 data_to_ram bytes not yet written in the current run keep their prior values; bytes are never partially updated.

Reset
REQ-034 iRst=1 asynchronously forces IDLE, row=0, WAIT counter=0, busy=0, done=0, and overflow=0, and sets addr_to_rom, both operand outputs, data_to_ram, and the bias register to 0.
REQ-035 iRst asserted mid-run aborts the run with no further writes; after release, the block waits in IDLE for start.

Verification
REQ-036 Defaults; biases all 8'h00; MultAdder returns 15'h0A00 for every row -> done at edge 52; every data_to_ram byte = 8'h14; overflow=0.
REQ-037 Negative result 15'h4A00 on row 3, relu_en=1 -> byte 3 = 8'h00; same stimulus with relu_en=0 -> byte 3 = 8'h94.
REQ-038 overflow_from_MultAdder pulsed only during row 7's ADD -> overflow=1 at done and still 1 in DONE; next start clears it to 0.
REQ-039 iRst pulsed during row 5 WAIT -> all outputs 0 immediately; start after release -> full run completes correctly.
REQ-040 ena held low 6 cycles during row 2, plus a start pulse during the run -> done at edge 58; start ignored; results identical to REQ-036.
REQ-041 N_OUT=4, MAC_LAT=3 -> done at edge 30; addr_to_rom sequence B_BASE, W_BASE..W_BASE+3; data_to_ram is 32 bits.
